// File: rtl/serializador_paralelo_serial_pkg.sv
// Shared definitions for the serializer and the detector bench:
// state encoding, default word shape and the counter width helper.
package serializador_paralelo_serial_pkg;

  typedef enum logic {
    OCIOSO     = 1'b0,
    DESLOCANDO = 1'b1
  } estado_t;

  localparam int WIDTH_DEF     = 8;
  localparam bit MSB_FIRST_DEF = 1'b1;
  localparam bit IDLE_BIT_DEF  = 1'b0;

  function automatic int cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serializador_paralelo_serial_if.sv
// Word-in / bit-out bundle between upstream, serializer and detector.
// master = upstream side, slave = the serializer.
interface serializador_paralelo_serial_if
  import serializador_paralelo_serial_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);

  logic [WIDTH-1:0] dado;
  logic             dado_valido;
  logic             pronto;
  logic             x;
  logic             x_valido;
  logic             ocupado;

  modport master (
    output dado,
    output dado_valido,
    input  pronto,
    input  x,
    input  x_valido,
    input  ocupado
  );

  modport slave (
    input  dado,
    input  dado_valido,
    output pronto,
    output x,
    output x_valido,
    output ocupado
  );

endinterface

// File: rtl/serializador_paralelo_serial.sv
// Parallel-to-serial converter with gapless back-to-back words;
// the line idles at IDLE_BIT because the detector has no enable.
module serializador_paralelo_serial
  import serializador_paralelo_serial_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter bit MSB_FIRST = MSB_FIRST_DEF,
  parameter bit IDLE_BIT  = IDLE_BIT_DEF
) (
  input logic clock,
  input logic reset,
  serializador_paralelo_serial_if.slave bus
);

  localparam int            CW      = cnt_w(WIDTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

  estado_t          est_q, est_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             x_q, x_d;
  logic             xv_q, xv_d;
  logic             oc_q, oc_d;
  logic             ultimo;
  logic             aceita;

  function automatic logic primeiro(
    input logic [WIDTH-1:0] w
  );
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] desloca(
    input logic [WIDTH-1:0] w
  );
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  // last bit on the line: next word may be taken this cycle
  assign ultimo     = (cnt_q == CNT_MAX);
  assign bus.pronto = (est_q == OCIOSO) || ultimo;
  assign aceita     = bus.dado_valido && bus.pronto;

  assign bus.x        = x_q;
  assign bus.x_valido = xv_q;
  assign bus.ocupado  = oc_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      est_q <= OCIOSO;
    end else begin
      est_q <= est_d;
    end
  end

  always_comb begin
    est_d = est_q;
    unique case (est_q)
      OCIOSO: begin
        if (aceita) est_d = DESLOCANDO;
      end
      DESLOCANDO: begin
        if (ultimo && !aceita) est_d = OCIOSO;
      end
      default: est_d = OCIOSO;
    endcase
  end

  // aceita and mid-word shifting never overlap: pronto is
  // low in DESLOCANDO until the last bit
  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    x_d   = IDLE_BIT;
    xv_d  = 1'b0;
    oc_d  = 1'b0;
    unique case (1'b1)
      aceita: begin
        sr_d  = bus.dado;
        cnt_d = '0;
        x_d   = primeiro(bus.dado);
        xv_d  = 1'b1;
        oc_d  = 1'b1;
      end
      (est_q == DESLOCANDO) && !ultimo: begin
        sr_d  = desloca(sr_q);
        cnt_d = cnt_q + 1'b1;
        x_d   = primeiro(desloca(sr_q));
        xv_d  = 1'b1;
        oc_d  = 1'b1;
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sr_q  <= '0;
      cnt_q <= '0;
      x_q   <= IDLE_BIT;
      xv_q  <= 1'b0;
      oc_q  <= 1'b0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
      x_q   <= x_d;
      xv_q  <= xv_d;
      oc_q  <= oc_d;
    end
  end

endmodule

// File: tb/tb_serializador_paralelo_serial.sv
// Bench for the serializer: MSB-first and LSB-first instances share
// stimulus and are checked against a bit-queue line model.
module tb_serializador_paralelo_serial;
  import serializador_paralelo_serial_pkg::*;

  localparam int W = WIDTH_DEF;

  logic         clk  = 1'b0;
  logic         rst  = 1'b0;
  logic [W-1:0] dado = '0;
  logic         vld  = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  // bits still to appear on x, front = bit on the line now
  bit qm[$];
  bit ql[$];

  always #5 clk = ~clk;

  serializador_paralelo_serial_if #(.WIDTH(W)) im ();
  serializador_paralelo_serial_if #(.WIDTH(W)) il ();

  assign im.dado        = dado;
  assign im.dado_valido = vld;
  assign il.dado        = dado;
  assign il.dado_valido = vld;

  serializador_paralelo_serial #(
    .WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(IDLE_BIT_DEF)
  ) u_msb (
    .clock(clk), .reset(rst), .bus(im)
  );

  serializador_paralelo_serial #(
    .WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(IDLE_BIT_DEF)
  ) u_lsb (
    .clock(clk), .reset(rst), .bus(il)
  );

  // {x, x_valido, ocupado, pronto} for msb then lsb instance
  function automatic logic [7:0] exp_vec();
    logic em, el;
    em = (qm.size() != 0) ? qm[0] : IDLE_BIT_DEF;
    el = (ql.size() != 0) ? ql[0] : IDLE_BIT_DEF;
    return {em, qm.size() != 0, qm.size() != 0, qm.size() <= 1,
            el, ql.size() != 0, ql.size() != 0, ql.size() <= 1};
  endfunction

  function automatic logic [7:0] obs_vec();
    return {im.x, im.x_valido, im.ocupado, im.pronto,
            il.x, il.x_valido, il.ocupado, il.pronto};
  endfunction

  // advance one clock, update the line model, stop at the negedge
  task automatic tick();
    logic acc;
    bit   b;
    @(posedge clk);
    acc = !rst && vld && (qm.size() <= 1);
    if (rst) begin
      qm.delete();
      ql.delete();
    end else begin
      if (qm.size() != 0) b = qm.pop_front();
      if (ql.size() != 0) b = ql.pop_front();
      if (acc) begin
        for (int i = 0; i < W; i++) begin
          qm.push_back(dado[W-1-i]);
          ql.push_back(dado[i]);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [7:0] o, e;
    #2 rst = 1'b1;
    repeat (2) tick();
    o = obs_vec(); e = exp_vec(); n_cmp++;
    if (o !== e) begin
      n_bad++;
      $display("FAIL reset_hold got %b want %b", o, e);
    end
    rst = 1'b0;
    vld = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      o = obs_vec(); e = exp_vec(); n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL idle cyc%0d got %b want %b", c, o, e);
      end
    end
  endtask

  task automatic test_single(input logic [W-1:0] w);
    logic [7:0] o, e;
    dado = w;
    vld  = 1'b1;
    for (int c = 0; c < 11; c++) begin
      tick();
      vld  = 1'b0;
      dado = W'($urandom);
      o = obs_vec(); e = exp_vec(); n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL single %h cyc%0d got %b want %b", w, c, o, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] o, e;
    int rm, rl, mm, ml;
    rm = 0; rl = 0; mm = 0; ml = 0;
    dado = 8'hA5;
    vld  = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (c == 0) dado = 8'h3C;
      if (c == 8) vld = 1'b0;
      o = obs_vec(); e = exp_vec(); n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL b2b cyc%0d got %b want %b", c, o, e);
      end
      rm = im.x_valido ? rm + 1 : 0;
      rl = il.x_valido ? rl + 1 : 0;
      if (rm > mm) mm = rm;
      if (rl > ml) ml = rl;
    end
    n_cmp++;
    if (mm != 2 * W) begin
      n_bad++;
      $display("FAIL b2b_run_msb got %0d want %0d", mm, 2 * W);
    end
    n_cmp++;
    if (ml != 2 * W) begin
      n_bad++;
      $display("FAIL b2b_run_lsb got %0d want %0d", ml, 2 * W);
    end
  endtask

  task automatic test_busy();
    logic [7:0] o, e;
    dado = W'($urandom);
    vld  = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (c == 0) vld = 1'b0;
      if (c == 1) begin
        dado = 8'hFF;
        vld  = 1'b1;
      end
      if (c == 8) vld = 1'b0;
      o = obs_vec(); e = exp_vec(); n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL busy cyc%0d got %b want %b", c, o, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] o, e;
    dado = 8'hF0;
    vld  = 1'b1;
    tick();
    vld = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    qm.delete();
    ql.delete();
    #1;
    o = obs_vec(); e = exp_vec(); n_cmp++;
    if (o !== e) begin
      n_bad++;
      $display("FAIL reset_async got %b want %b", o, e);
    end
    tick();
    rst = 1'b0;
    dado = 8'h81;
    vld  = 1'b1;
    for (int c = 0; c < 11; c++) begin
      tick();
      vld = 1'b0;
      o = obs_vec(); e = exp_vec(); n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL after_reset cyc%0d got %b want %b", c, o, e);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] o, e;
    for (int c = 0; c < 400; c++) begin
      tick();
      o = obs_vec(); e = exp_vec(); n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL random cyc%0d got %b want %b", c, o, e);
      end
      rst  = ($urandom_range(0, 59) == 0);
      vld  = ($urandom_range(0, 3) != 0);
      dado = W'($urandom);
    end
    rst = 1'b0;
    vld = 1'b0;
    for (int c = 0; c < W + 2; c++) begin
      tick();
      o = obs_vec(); e = exp_vec(); n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL drain cyc%0d got %b want %b", c, o, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single(8'hD2);
    test_single(W'($urandom));
    test_single(8'h01);
    test_back_to_back();
    test_busy();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
